// File: rtl/fmlbrg_linexfer.sv
// Moves one 32-byte cache line (4 x 64-bit beats) between FML and the data memory.
// The writeback path is compiled in only when FMLBRG_WRITEBACK_EN is defined.
module fmlbrg_linexfer #(
  parameter int depth     = 11,
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 refill_req,
  input  logic                 wb_req,
  input  logic [fml_depth-6:0] line_adr,
  output logic                 busy,
  output logic                 done,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [7:0]           fml_sel,
  input  logic [63:0]          fml_di,
  output logic [63:0]          fml_do,
  output logic [depth-1:0]     dm_a,
  output logic [7:0]           dm_we,
  output logic [63:0]          dm_di,
  output logic [depth-1:0]     dm_a2,
  input  logic [63:0]          dm_do2
);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_BURST, RD_REQ, RD_BURST} state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [fml_depth-6:0] adr_q, adr_d;
  logic                 done_q, done_d;
  logic [depth-3:0]     line_idx;

  assign line_idx = adr_q[depth-3:0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      adr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      done_q  <= done_d;
    end
  end

`ifdef FMLBRG_WRITEBACK_EN
  logic [depth-1:0] dm_a2_c;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    done_d  = 1'b0;
    fml_stb = 1'b0;
    fml_we  = 1'b0;
    dm_we   = 8'h00;
    dm_a    = {line_idx, cnt_q};
`ifdef FMLBRG_WRITEBACK_EN
    dm_a2_c = {line_idx, 2'b00};
`endif
    case (state_q)
      IDLE: begin
`ifdef FMLBRG_WRITEBACK_EN
        // Present word 0 while idle so its data is ready in the first WB_REQ cycle.
        dm_a2_c = {line_adr[depth-3:0], 2'b00};
        if (wb_req) begin
          state_d = WB_REQ;
          adr_d   = line_adr;
        end else
`endif
        if (refill_req) begin
          state_d = RD_REQ;
          adr_d   = line_adr;
        end
      end
      RD_REQ: begin
        fml_stb = 1'b1;
        if (fml_ack) begin
          dm_we   = 8'hFF;
          dm_a    = {line_idx, 2'b00};
          state_d = RD_BURST;
          cnt_d   = 2'd1;
        end
      end
      RD_BURST: begin
        dm_we = 8'hFF;
        if (cnt_q == 2'd3) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`ifdef FMLBRG_WRITEBACK_EN
      WB_REQ: begin
        fml_stb = 1'b1;
        fml_we  = 1'b1;
        if (fml_ack) begin
          dm_a2_c = {line_idx, 2'b01};
          state_d = WB_BURST;
          cnt_d   = 2'd1;
        end
      end
      WB_BURST: begin
        // Address runs one word ahead so the synchronous read lands on the next beat.
        dm_a2_c = {line_idx, cnt_q + 2'd1};
        if (cnt_q == 2'd3) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign fml_adr = {adr_q, 5'b00000};
  assign fml_sel = 8'hFF;
  assign dm_di   = fml_di;

`ifdef FMLBRG_WRITEBACK_EN
  assign dm_a2  = dm_a2_c;
  assign fml_do = dm_do2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_req, dm_do2};
  assign dm_a2     = '0;
  assign fml_do    = 64'd0;
`endif

endmodule
